// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: UART (8N1) command front end for the on-chip debugger.
// Collects opcode/address/data frames from srx, issues one strobe per command to the
// debug controller and sends the read data or an ack byte back over stx.
// Optional build macro: UART_CMD_TIMEOUT_EN discards stale partial frames.

module uart_cmd_decoder #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        srx,
    output logic        stx,
    input  logic        ctrlr_busy,
    input  logic [31:0] d_rd,
    output logic [3:0]  debug_fn,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    output logic        out_valid,
    output logic        frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BitLast    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CntOne     = CW'(1);

    localparam logic [7:0] OpFirstAddr = 8'd5;
    localparam logic [7:0] OpMemWr     = 8'd8;
    localparam logic [7:0] OpRegWr     = 8'd10;
    localparam logic [7:0] OpLast      = 8'd10;
    localparam logic [3:0] FnStatus    = 4'd4;
    localparam logic [3:0] FnMemRd     = 4'd7;
    localparam logic [3:0] FnRegRd     = 4'd9;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e     rx_state, rx_state_d;
    logic          srx_meta, srx_sync, srx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_start, rx_done, rx_ferr;

    assign rx_start = (rx_state == RxIdle) && srx_prev && !srx_sync;
    assign rx_done  = (rx_state == RxStop) && (rx_cnt == BitLast) && srx_sync;
    assign rx_ferr  = (rx_state == RxStop) && (rx_cnt == BitLast) && !srx_sync;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            srx_meta <= 1'b1;
            srx_sync <= 1'b1;
            srx_prev <= 1'b1;
        end else begin
            srx_meta <= srx;
            srx_sync <= srx_meta;
            srx_prev <= srx_sync;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RxIdle;
        end else begin
            rx_state <= rx_state_d;
        end
    end

    // RX next state: start bit re-checked at half a bit, then mid-bit sampling.
    always_comb begin
        rx_state_d = rx_state;
        case (rx_state)
            RxIdle:  if (rx_start) rx_state_d = RxStart;
            RxStart: if (rx_cnt == HalfLast) rx_state_d = srx_sync ? RxIdle : RxData;
            RxData:  if ((rx_cnt == BitLast) && (rx_bit == 3'd7)) rx_state_d = RxStop;
            RxStop:  if (rx_cnt == BitLast) rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX bit timer and LSB-first shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            if (rx_state == RxIdle) begin
                rx_cnt <= '0;
            end else if ((rx_state == RxStart && rx_cnt == HalfLast) || rx_cnt == BitLast) begin
                rx_cnt <= '0;
            end else begin
                rx_cnt <= rx_cnt + CntOne;
            end
            if (rx_state == RxStart) begin
                rx_bit <= 3'd0;
            end else if (rx_state == RxData && rx_cnt == BitLast) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {srx_sync, rx_shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {StCollect, StIssue, StWaitDone, StReply, StErrReply} state_e;

    state_e      state, state_d;
    logic [3:0]  byte_cnt;
    logic [7:0]  op_q;
    logic [31:0] addr_sh, data_sh;
    logic [7:0]  cur_op;
    logic [3:0]  frame_len;
    logic        bad_op, frame_last, timeout, fn_is_read;
    logic        tx_start, tx_done;
    logic [31:0] tx_word_d;
    logic [2:0]  tx_bytes_d;

    // Frame length is decided by the opcode, which may be arriving right now.
    always_comb begin
        cur_op = (byte_cnt == 4'd0) ? rx_shift : op_q;
        bad_op = cur_op > OpLast;
        if (bad_op || cur_op < OpFirstAddr) begin
            frame_len = 4'd1;
        end else if (cur_op == OpMemWr || cur_op == OpRegWr) begin
            frame_len = 4'd9;
        end else begin
            frame_len = 4'd5;
        end
        frame_last = rx_done && !timeout && (byte_cnt + 4'd1 == frame_len);
        fn_is_read = (debug_fn == FnStatus) || (debug_fn == FnMemRd) || (debug_fn == FnRegRd);
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 160 * CLKS_PER_BIT;
    localparam int unsigned TW        = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] ToLast  = TW'(TO_CYCLES - 1);

    logic [TW-1:0] to_cnt;

    assign timeout = (state == StCollect) && (byte_cnt != 4'd0) && (to_cnt == ToLast);

    // Idle timer for a partial frame; restarted by every start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state != StCollect || byte_cnt == 4'd0 || rx_start || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Command FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= StCollect;
        end else begin
            state <= state_d;
        end
    end

    // Command FSM next state.
    always_comb begin
        state_d = state;
        case (state)
            StCollect:  if (frame_last) state_d = bad_op ? StErrReply : StIssue;
            StIssue:    if (!ctrlr_busy) state_d = StWaitDone;
            StWaitDone: if (!ctrlr_busy) state_d = StReply;
            StReply:    if (tx_done) state_d = StCollect;
            StErrReply: if (tx_done) state_d = StCollect;
            default:    state_d = StCollect;
        endcase
    end

    // Command FSM outputs: strobe and reply launch (d_rd is captured by the TX load).
    always_comb begin
        out_valid  = (state == StIssue) && !ctrlr_busy;
        tx_start   = 1'b0;
        tx_word_d  = 32'h0;
        tx_bytes_d = 3'd1;
        if (state == StWaitDone && !ctrlr_busy) begin
            tx_start = 1'b1;
            if (fn_is_read) begin
                tx_word_d  = d_rd;
                tx_bytes_d = 3'd4;
            end else begin
                tx_word_d = {4'hA, debug_fn, 24'h0};
            end
        end else if (state == StCollect && frame_last && bad_op) begin
            tx_start  = 1'b1;
            tx_word_d = {8'hEE, 24'h0};
        end
    end

    // Frame assembly; command outputs load only on the final byte and then hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= 4'd0;
            op_q     <= 8'h00;
            addr_sh  <= 32'h0;
            data_sh  <= 32'h0;
            debug_fn <= 4'd0;
            addr     <= 32'h0;
            d_in     <= 32'h0;
        end else if (state == StCollect) begin
            if (rx_ferr || timeout) begin
                byte_cnt <= 4'd0;
            end else if (rx_done) begin
                if (frame_last) begin
                    byte_cnt <= 4'd0;
                    if (!bad_op) begin
                        debug_fn <= cur_op[3:0];
                        case (frame_len)
                            4'd5:    addr <= {addr_sh[23:0], rx_shift};
                            4'd9:    addr <= addr_sh;
                            default: addr <= 32'h0;
                        endcase
                        d_in <= (frame_len == 4'd9) ? {data_sh[23:0], rx_shift} : 32'h0;
                    end
                end else begin
                    byte_cnt <= byte_cnt + 4'd1;
                    if (byte_cnt == 4'd0) begin
                        op_q <= rx_shift;
                    end else if (byte_cnt <= 4'd4) begin
                        addr_sh <= {addr_sh[23:0], rx_shift};
                    end else begin
                        data_sh <= {data_sh[23:0], rx_shift};
                    end
                end
            end
        end
    end

    // Framing errors (and, when enabled, stale-frame timeouts) as a one-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= rx_ferr || timeout;
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic          tx_active;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;   // 0 = start, 1..8 = data, 9 = stop
    logic [2:0]    tx_left;
    logic [31:0]   tx_word;
    logic [7:0]    tx_byte;

    assign tx_byte = tx_word[31:24];
    assign tx_done = tx_active && (tx_bit == 4'd9) && (tx_cnt == BitLast) && (tx_left == 3'd1);

    // Serializer: the line itself is a register so reset forces it high at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= 4'd0;
            tx_left   <= 3'd0;
            tx_word   <= 32'h0;
            stx       <= 1'b1;
        end else if (tx_start) begin
            tx_active <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= 4'd0;
            tx_left   <= tx_bytes_d;
            tx_word   <= tx_word_d;
            stx       <= 1'b0;
        end else if (tx_active) begin
            if (tx_cnt == BitLast) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    if (tx_left > 3'd1) begin
                        // Next byte starts straight after the stop bit.
                        tx_left <= tx_left - 3'd1;
                        tx_word <= {tx_word[23:0], 8'h00};
                        tx_bit  <= 4'd0;
                        stx     <= 1'b0;
                    end else begin
                        tx_active <= 1'b0;
                        stx       <= 1'b1;
                    end
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                    stx    <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
                end
            end else begin
                tx_cnt <= tx_cnt + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: table of command frames plus hand-written
// sequences for framing error, busy controller and asynchronous reset.

module tb_uart_cmd_decoder;

    localparam int CPB    = 10;
    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        srx;
    logic        stx;
    logic        ctrlr_busy;
    logic [31:0] d_rd;
    logic [3:0]  debug_fn;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        out_valid;
    logic        frame_err;

    logic hold_busy;
    logic model_busy;
    assign ctrlr_busy = hold_busy | model_busy;

    uart_cmd_decoder #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .srx       (srx),
        .stx       (stx),
        .ctrlr_busy(ctrlr_busy),
        .d_rd      (d_rd),
        .debug_fn  (debug_fn),
        .addr      (addr),
        .d_in      (d_in),
        .out_valid (out_valid),
        .frame_err (frame_err)
    );

    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        logic [71:0] bytes;   // byte 0 in [71:64]
        int          n;
        int          hold;    // busy cycles after the strobe
        logic [31:0] rd;
        bit          strobe;
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] din;
        int          nrep;
        logic [31:0] rep;     // reply bytes, first in [31:24]
    } vec_t;

    typedef struct {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] din;
    } strobe_t;

    int checks   = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int rep_cnt    = 0;
    int fe_cnt     = 0;
    int busy_hold  = 0;
    bit mon_ignore = 1'b0;
    time t_strobe  = 0;
    time t_txstart = 0;

    logic [7:0] rep_q[$];
    strobe_t    strobe_q[$];
    vec_t       vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [71:0] bytes, input int n, input int hold,
                                input logic [31:0] rd, input bit strobe, input logic [3:0] fn,
                                input logic [31:0] a, input logic [31:0] din, input int nrep,
                                input logic [31:0] rep);
        vec_t v;
        v.bytes = bytes; v.n = n; v.hold = hold; v.rd = rd; v.strobe = strobe;
        v.fn = fn; v.a = a; v.din = din; v.nrep = nrep; v.rep = rep;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        srx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            srx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        srx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
        srx = 1'b1;
    endtask

    task automatic wait_reps(input int target);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (rep_cnt >= target) break;
            @(negedge clk);
        end
        check("reply_bytes_arrived", 32'(rep_cnt >= target), 32'd1);
    endtask

    task automatic run_cmd(input vec_t v);
        strobe_t e;
        int s0;
        int r0;
        s0 = strobe_cnt;
        r0 = rep_cnt;
        d_rd = v.rd;
        busy_hold = v.hold;
        if (v.strobe) begin
            e.fn = v.fn; e.a = v.a; e.din = v.din;
            strobe_q.push_back(e);
        end
        for (int i = 0; i < v.nrep; i++) rep_q.push_back(v.rep[31-8*i -: 8]);
        for (int i = 0; i < v.n; i++) send_byte(v.bytes[71-8*i -: 8], 1'b0);
        wait_reps(r0 + v.nrep);
        repeat (20) @(negedge clk);
        check("strobe_count", 32'(strobe_cnt - s0), 32'(v.strobe));
        if (v.strobe) begin
            check("hold_debug_fn", 32'(debug_fn), 32'(v.fn));
            check("hold_addr", addr, v.a);
            check("hold_d_in", d_in, v.din);
        end
    endtask

    // Controller model and strobe scoreboard.
    initial begin
        strobe_t e;
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                strobe_cnt++;
                t_strobe = $time;
                check("strobe_expected", 32'(strobe_q.size() != 0), 32'd1);
                if (strobe_q.size() != 0) begin
                    e = strobe_q.pop_front();
                    check("strobe_fn", 32'(debug_fn), 32'(e.fn));
                    check("strobe_addr", addr, e.a);
                    check("strobe_d_in", d_in, e.din);
                end
                if (busy_hold > 0) begin
                    @(posedge clk);
                    #1 model_busy = 1'b1;
                    repeat (busy_hold) @(posedge clk);
                    #1 model_busy = 1'b0;
                end
            end
        end
    end

    // Frame error pulse counter.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) fe_cnt++;
        end
    end

    // UART receiver on stx; compares each reply byte against the scoreboard.
    initial begin
        logic [7:0] b;
        logic       start_ok;
        logic       stop_ok;
        forever begin
            @(negedge clk);
            if (stx === 1'b0 && reset_n === 1'b1) begin
                t_txstart = $time;
                repeat (CPB / 2) @(negedge clk);
                start_ok = (stx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = stx;
                end
                repeat (CPB) @(negedge clk);
                stop_ok = (stx === 1'b1);
                rep_cnt++;
                if (!mon_ignore) begin
                    check("tx_start_bit", 32'(start_ok), 32'd1);
                    check("tx_stop_bit", 32'(stop_ok), 32'd1);
                    check("reply_expected", 32'(rep_q.size() != 0), 32'd1);
                    if (rep_q.size() != 0) check("reply_byte", 32'(b), 32'(rep_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int f0;
        int k;
        vec_t resume_v;
        vec_t rst_v;

        vecs[0] = mk(72'h00_00000000_00000000, 1, 5, 32'h0, 1, 4'd0, 32'h0, 32'h0, 1,
                     32'hA0000000);
        vecs[1] = mk(72'h07_00001000_00000000, 5, 3, 32'hDEADBEEF, 1, 4'd7, 32'h00001000,
                     32'h0, 4, 32'hDEADBEEF);
        vecs[2] = mk(72'h08_00000004_12345678, 9, 2, 32'h0, 1, 4'd8, 32'h4, 32'h12345678, 1,
                     32'hA8000000);
        vecs[3] = mk(72'h0F_00000000_00000000, 1, 0, 32'h0, 0, 4'd0, 32'h0, 32'h0, 1,
                     32'hEE000000);
        vecs[4] = mk(72'h04_00000000_00000000, 1, 0, 32'h0102A5C3, 1, 4'd4, 32'h0, 32'h0, 4,
                     32'h0102A5C3);
        vecs[5] = mk(72'h0A_00000011_CAFEF00D, 9, 1, 32'h0, 1, 4'd10, 32'h11, 32'hCAFEF00D, 1,
                     32'hAA000000);
        vecs[6] = mk(72'h06_89ABCDEF_00000000, 5, 0, 32'h0, 1, 4'd6, 32'h89ABCDEF, 32'h0, 1,
                     32'hA6000000);
        vecs[7] = mk(72'h09_00000003_00000000, 5, 4, 32'h80000001, 1, 4'd9, 32'h3, 32'h0, 4,
                     32'h80000001);
        resume_v = mk(72'h01_00000000_00000000, 1, 0, 32'h0, 1, 4'd1, 32'h0, 32'h0, 1,
                      32'hA1000000);
        rst_v = mk(72'h03_00000000_00000000, 1, 2, 32'h0, 1, 4'd3, 32'h0, 32'h0, 1,
                   32'hA3000000);

        srx = 1'b1;
        reset_n = 1'b0;
        hold_busy = 1'b0;
        d_rd = 32'h0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_stx", 32'(stx), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_debug_fn", 32'(debug_fn), 32'd0);
        check("rst_addr", addr, 32'h0);
        check("rst_d_in", d_in, 32'h0);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

        // Bad stop bit on the second byte of BR_PT_ADD, then a clean RESUME.
        s0 = strobe_cnt;
        f0 = fe_cnt;
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (30) @(negedge clk);
        check("ferr_pulses", 32'(fe_cnt - f0), 32'd1);
        check("ferr_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        run_cmd(resume_v);
        check("one_cycle_done_latency", 32'(t_txstart - t_strobe), 32'(2 * PERIOD));
        check("resume_no_ferr", 32'(fe_cnt - f0), 32'd1);

        // Controller stuck busy: no strobe, then reset aborts the pending issue.
        hold_busy = 1'b1;
        s0 = strobe_cnt;
        send_byte(8'h02, 1'b0);
        repeat (30) @(negedge clk);
        check("busy_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("busy_out_valid", 32'(out_valid), 32'd0);
        check("busy_debug_fn", 32'(debug_fn), 32'd2);
        #3 reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_debug_fn", 32'(debug_fn), 32'd0);
        check("arst_addr", addr, 32'h0);
        check("arst_d_in", d_in, 32'h0);
        check("arst_frame_err", 32'(frame_err), 32'd0);
        check("arst_stx", 32'(stx), 32'd1);
        hold_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_issue_aborted", 32'(strobe_cnt - s0), 32'd0);

        // Reset in the middle of a reply drives stx high at once.
        mon_ignore = 1'b1;
        send_byte(8'h0F, 1'b0);
        for (k = 0; k < 50; k++) begin
            if (stx === 1'b0) break;
            @(negedge clk);
        end
        check("err_reply_started", 32'(stx), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_mid_tx_stx", 32'(stx), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (150) @(negedge clk);
        mon_ignore = 1'b0;
        run_cmd(rst_v);

        check("reply_queue_empty", 32'(rep_q.size()), 32'd0);
        check("strobe_queue_empty", 32'(strobe_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
